reorder_buffer: RTL and testbench

In-order retirement buffer for the out-of-order core. It sits between rename/dispatch, which allocates one entry per instruction and receives a ROB index, and the free list, which receives the retired instruction's old physical destination. Completion is signalled by the ALU and memory writeback ports. Entries retire strictly in program order, one per cycle, once complete.

---
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at tail, writeback ports mark
// entries complete, and the head entry retires once complete, one per cycle.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_alloc_valid,
    output logic              o_alloc_ready,
    input  logic [PREG_W-1:0] i_alloc_pd_new,
    input  logic [PREG_W-1:0] i_alloc_pd_old,
    input  logic              i_alloc_has_rd,
    input  logic [31:0]       i_alloc_pc,
    output logic [IDX_W-1:0]  o_alloc_index,
    input  logic              i_wb_alu_valid,
    input  logic [IDX_W-1:0]  i_wb_alu_index,
    input  logic              i_wb_mem_valid,
    input  logic [IDX_W-1:0]  i_wb_mem_index,
    input  logic              i_flush,
    output logic              o_retire_valid,
    output logic [PREG_W-1:0] o_retire_pd_old,
    output logic [PREG_W-1:0] o_retire_pd_new,
    output logic              o_retire_has_rd,
    output logic [31:0]       o_retire_pc,
    output logic [IDX_W:0]    o_count,
    output logic              o_empty,
    output logic              o_full
);

    typedef struct packed {
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
        logic              has_rd;
        logic [31:0]       pc;
    } rob_entry_t;

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    rob_entry_t         r_entry [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_complete;
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;

    logic               r_ret_valid;
    rob_entry_t         r_ret;

    logic               w_full;
    logic               w_alloc;
    logic               w_retire;
    logic [IDX_W:0]     w_inc;
    logic [IDX_W:0]     w_dec;

    assign w_full   = (r_count == FULL_CNT);
    assign w_alloc  = i_alloc_valid & o_alloc_ready;
    assign w_retire = ~i_flush & r_valid[r_head] & r_complete[r_head];
    assign w_inc    = {{IDX_W{1'b0}}, w_alloc};
    assign w_dec    = {{IDX_W{1'b0}}, w_retire};

    assign o_alloc_ready = ~w_full & ~i_flush;
    assign o_alloc_index = r_tail;
    assign o_count       = r_count;
    assign o_empty       = (r_count == '0);
    assign o_full        = w_full;

    assign o_retire_valid  = r_ret_valid;
    assign o_retire_pd_old = r_ret.pd_old;
    assign o_retire_pd_new = r_ret.pd_new;
    assign o_retire_has_rd = r_ret.has_rd;
    assign o_retire_pc     = r_ret.pc;

    // Control state; later assignments in the block take precedence, so an
    // allocation clears complete even if a stray writeback hit the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (i_flush) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (i_wb_alu_valid && r_valid[i_wb_alu_index]) begin
                r_complete[i_wb_alu_index] <= 1'b1;
            end
            if (i_wb_mem_valid && r_valid[i_wb_mem_index]) begin
                r_complete[i_wb_mem_index] <= 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail]    <= 1'b1;
                r_complete[r_tail] <= 1'b0;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head]    <= 1'b0;
                r_complete[r_head] <= 1'b0;
                r_head             <= r_head + 1'b1;
            end
            r_count <= r_count + w_inc - w_dec;
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_entry[r_tail] <= '{
                pd_new: i_alloc_pd_new,
                pd_old: i_alloc_pd_old,
                has_rd: i_alloc_has_rd,
                pc:     i_alloc_pc
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_valid <= 1'b0;
            r_ret       <= '0;
        end else begin
            r_ret_valid <= w_retire;
            if (w_retire) begin
                r_ret <= r_entry[r_head];
            end
        end
    end

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst_n) r_count <= FULL_CNT
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    logic        has_rd;
    logic [31:0] pc;
    logic [3:0]  alloc_index;
    logic        wb_alu_valid;
    logic [3:0]  wb_alu_index;
    logic        wb_mem_valid;
    logic [3:0]  wb_mem_index;
    logic        flush;
    logic        ret_valid;
    logic [6:0]  ret_pd_old;
    logic [6:0]  ret_pd_new;
    logic        ret_has_rd;
    logic [31:0] ret_pc;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .PREG_W(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_alloc_valid   (alloc_valid),
        .o_alloc_ready   (alloc_ready),
        .i_alloc_pd_new  (pd_new),
        .i_alloc_pd_old  (pd_old),
        .i_alloc_has_rd  (has_rd),
        .i_alloc_pc      (pc),
        .o_alloc_index   (alloc_index),
        .i_wb_alu_valid  (wb_alu_valid),
        .i_wb_alu_index  (wb_alu_index),
        .i_wb_mem_valid  (wb_mem_valid),
        .i_wb_mem_index  (wb_mem_index),
        .i_flush         (flush),
        .o_retire_valid  (ret_valid),
        .o_retire_pd_old (ret_pd_old),
        .o_retire_pd_new (ret_pd_new),
        .o_retire_has_rd (ret_has_rd),
        .o_retire_pc     (ret_pc),
        .o_count         (count),
        .o_empty         (empty),
        .o_full          (full)
    );

    always #5 clk = ~clk;

    // Reference model: entries held in program order
    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [6:0]  pdn;
        logic [6:0]  pdo;
        logic        hrd;
        bit          cmp;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [6:0]  m_rpdn;
    logic [6:0]  m_rpdo;
    logic        m_rhrd;

    task automatic m_reset();
        q.delete();
        m_tail = 0;
        m_rv   = 1'b0;
        m_rpc  = '0;
        m_rpdn = '0;
        m_rpdo = '0;
        m_rhrd = 1'b0;
    endtask

    task automatic model_step();
        bit   ret;
        ent_t e;
        if (flush) begin
            q.delete();
            m_tail = 0;
            m_rv   = 1'b0;
        end else begin
            ret = (q.size() > 0) && q[0].cmp;
            if (wb_alu_valid)
                foreach (q[i]) if (q[i].idx == int'(wb_alu_index)) q[i].cmp = 1;
            if (wb_mem_valid)
                foreach (q[i]) if (q[i].idx == int'(wb_mem_index)) q[i].cmp = 1;
            if (alloc_valid && q.size() < 16) begin
                e.idx = m_tail;
                e.pc  = pc;
                e.pdn = pd_new;
                e.pdo = pd_old;
                e.hrd = has_rd;
                e.cmp = 0;
                q.push_back(e);
                m_tail = (m_tail + 1) % 16;
            end
            if (ret) begin
                e      = q.pop_front();
                m_rv   = 1'b1;
                m_rpc  = e.pc;
                m_rpdn = e.pdn;
                m_rpdo = e.pdo;
                m_rhrd = e.hrd;
            end else begin
                m_rv = 1'b0;
            end
        end
    endtask

    task automatic idle();
        alloc_valid  = 0;
        pd_new       = '0;
        pd_old       = '0;
        has_rd       = 0;
        pc           = '0;
        wb_alu_valid = 0;
        wb_alu_index = '0;
        wb_mem_valid = 0;
        wb_mem_index = '0;
        flush        = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic alloc_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1;
            pc     = base + 32'(4 * i);
            pd_new = 7'(i + 32);
            pd_old = 7'(i + 10);
            has_rd = 1;
            step();
        end
        alloc_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        m_reset();
        #3;
        n_tests++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: count=%0d empty=%b full=%b want 0/1/0",
                     count, empty, full);
        end
        n_tests++;
        if (alloc_ready !== 1'b1 || ret_valid !== 1'b0 || alloc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: rdy=%b rv=%b idx=%0d want 1/0/0",
                     alloc_ready, ret_valid, alloc_index);
        end
        n_tests++;
        if (ret_pc !== 32'd0 || ret_pd_old !== 7'd0 || ret_pd_new !== 7'd0
            || ret_has_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ret: pc=%0h pdo=%0d pdn=%0d hrd=%b want 0",
                     ret_pc, ret_pd_old, ret_pd_new, ret_has_rd);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        alloc_valid = 1;
        pc          = 32'h100;
        pd_new      = 7'd40;
        pd_old      = 7'd5;
        has_rd      = 1;
        #1;
        n_tests++;
        if (alloc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL single_idx: got %0d want 0", alloc_index);
        end
        step();
        idle();
        n_tests++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cnt: got %0d want 1", count);
        end
        wb_alu_valid = 1;
        wb_alu_index = 4'd0;
        step();
        idle();
        n_tests++;
        if (ret_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: retire_valid=%b want 0", ret_valid);
        end
        step();
        n_tests++;
        if (ret_valid !== 1'b1 || ret_pd_old !== 7'd5 || ret_pd_new !== 7'd40
            || ret_has_rd !== 1'b1 || ret_pc !== 32'h100 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_ret: rv=%b pdo=%0d pdn=%0d hrd=%b pc=%0h cnt=%0d want 1/5/40/1/100/0",
                     ret_valid, ret_pd_old, ret_pd_new, ret_has_rd, ret_pc, count);
        end
        step();
        n_tests++;
        if (ret_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: retire_valid=%b want 0", ret_valid);
        end
    endtask

    task automatic test_out_of_order();
        int order [3] = '{2, 1, 0};
        do_reset();
        alloc_n(3, 32'h200);
        foreach (order[k]) begin
            wb_alu_valid = 1;
            wb_alu_index = 4'(order[k]);
            step();
            n_tests++;
            if (ret_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ooo_early: wb %0d retire_valid=%b want 0",
                         order[k], ret_valid);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (ret_valid !== 1'b1 || ret_pc !== 32'h200 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL ooo_order: rv=%b pc=%0h want 1/%0h",
                         ret_valid, ret_pc, 32'h200 + 32'(4 * i));
            end
        end
        step();
        n_tests++;
        if (ret_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL ooo_end: rv=%b cnt=%0d want 0/0", ret_valid, count);
        end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        alloc_n(16, 32'h300);
        alloc_valid = 1;
        pc = 32'h3fc;
        #1;
        n_tests++;
        if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_full: full=%b rdy=%b cnt=%0d want 1/0/16",
                     full, alloc_ready, count);
        end
        step();
        n_tests++;
        if (count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_17th: cnt=%0d want 16", count);
        end
        wb_alu_valid = 1;
        wb_alu_index = 4'd0;
        step();
        wb_alu_valid = 0;
        n_tests++;
        if (alloc_ready !== 1'b0 || ret_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_stall: rdy=%b rv=%b want 0/0", alloc_ready, ret_valid);
        end
        step();
        n_tests++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'h300 || count !== 5'd15) begin
            n_fail++;
            $display("FAIL fill_retire: rv=%b pc=%0h cnt=%0d want 1/300/15",
                     ret_valid, ret_pc, count);
        end
        pc = 32'h400;
        #1;
        n_tests++;
        if (alloc_ready !== 1'b1 || alloc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_wrap: rdy=%b idx=%0d want 1/0", alloc_ready, alloc_index);
        end
        step();
        alloc_valid = 0;
        n_tests++;
        if (count !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_refill: cnt=%0d full=%b want 16/1", count, full);
        end
    endtask

    task automatic test_dual_wb();
        int nret = 0;
        do_reset();
        alloc_n(4, 32'h500);
        wb_alu_valid = 1;
        wb_alu_index = 4'd3;
        wb_mem_valid = 1;
        wb_mem_index = 4'd3;
        step();
        wb_mem_valid = 0;
        wb_alu_index = 4'd9;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            if (ret_valid) nret++;
        end
        n_tests++;
        if (nret != 0 || count !== 5'd4) begin
            n_fail++;
            $display("FAIL dual_spurious: retires=%0d cnt=%0d want 0/4", nret, count);
        end
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i == 0) begin
                wb_alu_valid = 1;
                wb_alu_index = 4'd0;
                wb_mem_valid = 1;
                wb_mem_index = 4'd1;
            end else if (i == 1) begin
                wb_alu_valid = 1;
                wb_alu_index = 4'd2;
            end
            step();
            if (ret_valid) begin
                n_tests++;
                if (ret_pc !== 32'h500 + 32'(4 * nret)) begin
                    n_fail++;
                    $display("FAIL dual_order: pc=%0h want %0h",
                             ret_pc, 32'h500 + 32'(4 * nret));
                end
                nret++;
            end
        end
        idle();
        n_tests++;
        if (nret != 4 || count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_total: retires=%0d cnt=%0d want 4/0", nret, count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5, 32'h600);
        wb_alu_valid = 1;
        wb_alu_index = 4'd0;
        wb_mem_valid = 1;
        wb_mem_index = 4'd1;
        step();
        idle();
        flush       = 1;
        alloc_valid = 1;
        pc          = 32'h700;
        #1;
        n_tests++;
        if (alloc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rdy: rdy=%b want 0", alloc_ready);
        end
        step();
        idle();
        #1;
        n_tests++;
        if (count !== 5'd0 || empty !== 1'b1 || ret_valid !== 1'b0
            || alloc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_state: cnt=%0d empty=%b rv=%b idx=%0d want 0/1/0/0",
                     count, empty, ret_valid, alloc_index);
        end
        alloc_valid = 1;
        pc = 32'h800;
        step();
        idle();
        wb_alu_valid = 1;
        wb_alu_index = 4'd0;
        step();
        idle();
        step();
        n_tests++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'h800) begin
            n_fail++;
            $display("FAIL flush_after: rv=%b pc=%0h want 1/800", ret_valid, ret_pc);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_n(8, 32'h900);
        wb_alu_valid = 1;
        wb_alu_index = 4'd0;
        step();
        idle();
        step();
        n_tests++;
        if (ret_valid !== 1'b1 || count !== 5'd7) begin
            n_fail++;
            $display("FAIL mrst_pre: rv=%b cnt=%0d want 1/7", ret_valid, count);
        end
        #2;
        rst_n = 0;
        m_reset();
        #1;
        n_tests++;
        if (count !== 5'd0 || ret_valid !== 1'b0 || alloc_ready !== 1'b1
            || empty !== 1'b1 || ret_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL mrst_async: cnt=%0d rv=%b rdy=%b empty=%b pc=%0h want 0/0/1/1/0",
                     count, ret_valid, alloc_ready, empty, ret_pc);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        alloc_valid = 1;
        pc = 32'ha00;
        #1;
        n_tests++;
        if (alloc_index !== 4'd0) begin
            n_fail++;
            $display("FAIL mrst_idx: idx=%0d want 0", alloc_index);
        end
        step();
        idle();
        wb_mem_valid = 1;
        wb_mem_index = 4'd0;
        step();
        idle();
        step();
        n_tests++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'ha00 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL mrst_fresh: rv=%b pc=%0h cnt=%0d want 1/a00/0",
                     ret_valid, ret_pc, count);
        end
    endtask

    task automatic test_random();
        logic       exp_rdy;
        logic [3:0] exp_idx;
        logic [4:0] exp_cnt;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle();
            alloc_valid = ($urandom_range(9) < 6);
            pc     = $urandom();
            pd_new = 7'($urandom());
            pd_old = 7'($urandom());
            has_rd = 1'($urandom());
            wb_alu_valid = 1'($urandom());
            wb_mem_valid = 1'($urandom());
            if (q.size() > 0 && $urandom_range(3) != 0)
                wb_alu_index = 4'(q[$urandom_range(q.size() - 1)].idx);
            else
                wb_alu_index = 4'($urandom_range(15));
            if (q.size() > 0 && $urandom_range(3) != 0)
                wb_mem_index = 4'(q[$urandom_range(q.size() - 1)].idx);
            else
                wb_mem_index = 4'($urandom_range(15));
            flush = ($urandom_range(99) < 2);
            #1;
            exp_rdy = (q.size() < 16) && !flush;
            exp_idx = 4'(m_tail);
            exp_cnt = 5'(q.size());
            n_tests++;
            if (alloc_ready !== exp_rdy || alloc_index !== exp_idx
                || count !== exp_cnt || empty !== (exp_cnt == 5'd0)
                || full !== (exp_cnt == 5'd16)) begin
                n_fail++;
                $display("FAIL rand_state c%0d: rdy=%b idx=%0d cnt=%0d want %b/%0d/%0d",
                         cyc, alloc_ready, alloc_index, count, exp_rdy, exp_idx, exp_cnt);
            end
            step();
            n_tests++;
            if (ret_valid !== m_rv || ret_pc !== m_rpc || ret_pd_old !== m_rpdo
                || ret_pd_new !== m_rpdn || ret_has_rd !== m_rhrd) begin
                n_fail++;
                $display("FAIL rand_retire c%0d: rv=%b pc=%0h pdo=%0d pdn=%0d hrd=%b want %b/%0h/%0d/%0d/%b",
                         cyc, ret_valid, ret_pc, ret_pd_old, ret_pd_new, ret_has_rd,
                         m_rv, m_rpc, m_rpdo, m_rpdn, m_rhrd);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        m_reset();
        test_reset();
        test_single();
        test_out_of_order();
        test_fill_wrap();
        test_dual_wb();
        test_flush();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
